// File: rtl/cpu_pkg.sv
// Shared CPU definitions: datapath width, the canonical NOP encoding and the
// fetch-stage state type.
package cpu_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_DRAIN = 2'd2,
    S_HOLD  = 2'd3
  } fetch_state_t;

endpackage

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, runs the imem request/ready handshake and
// presents IF_instruction / IF_pcplus4 combinationally to the IF/ID register.
//
// Handshake: imem_req is valid-like and depends only on registered state; a
// request completes on any cycle where imem_req=1 and imem_ready=1, and imem_addr
// is held stable (it is always the PC) until that cycle.
module fetch_unit
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pc_write,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] IF_instruction,
  output logic [31:0] IF_pcplus4,
  output logic        if_valid,
  output logic [1:0]  dbg_state
);

  fetch_state_t         r_state;
  fetch_state_t         w_next_state;
  logic [XLEN-1:0]      r_pc;
  logic [XLEN-1:0]      r_hold_buf;
  logic [XLEN-1:0]      r_redirect_tgt;
  logic [XLEN-1:0]      w_next_pc;
  logic [XLEN-1:0]      w_next_hold;
  logic [XLEN-1:0]      w_next_rtgt;
  logic [XLEN-1:0]      w_target;
  logic [XLEN-1:0]      w_pc_plus4;

  assign w_target   = branch_target & ~32'h3;
  assign w_pc_plus4 = r_pc + 32'd4;
  assign imem_addr  = r_pc;
  assign IF_pcplus4 = w_pc_plus4;
  assign dbg_state  = r_state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state        <= S_IDLE;
      r_pc           <= RESET_PC;
      r_hold_buf     <= NOP_INSTR;
      r_redirect_tgt <= '0;
    end else begin
      r_state        <= w_next_state;
      r_pc           <= w_next_pc;
      r_hold_buf     <= w_next_hold;
      r_redirect_tgt <= w_next_rtgt;
    end
  end

  always_comb begin
    w_next_state   = r_state;
    w_next_pc      = r_pc;
    w_next_hold    = r_hold_buf;
    w_next_rtgt    = r_redirect_tgt;
    imem_req       = 1'b0;
    if_valid       = 1'b0;
    IF_instruction = NOP_INSTR;
    case (r_state)
      S_IDLE: begin
        if (branch_taken) w_next_pc = w_target;
        w_next_state = S_FETCH;
      end
      S_FETCH: begin
        imem_req = 1'b1;
        if (imem_ready) begin
          if (branch_taken) begin
            w_next_pc = w_target;
          end else begin
            if_valid       = 1'b1;
            IF_instruction = imem_rdata;
            if (pc_write) begin
              w_next_pc = w_pc_plus4;
            end else begin
              w_next_hold  = imem_rdata;
              w_next_state = S_HOLD;
            end
          end
        end else if (branch_taken) begin
          // The in-flight request cannot be withdrawn; remember where to go once it lands.
          w_next_rtgt  = w_target;
          w_next_state = S_DRAIN;
        end
      end
      S_DRAIN: begin
        imem_req = 1'b1;
        if (branch_taken) w_next_rtgt = w_target;
        if (imem_ready) begin
          w_next_pc    = branch_taken ? w_target : r_redirect_tgt;
          w_next_state = S_FETCH;
        end
      end
      S_HOLD: begin
        if (branch_taken) begin
          w_next_pc    = w_target;
          w_next_state = S_FETCH;
        end else begin
          if_valid       = 1'b1;
          IF_instruction = r_hold_buf;
          if (pc_write) begin
            w_next_pc    = w_pc_plus4;
            w_next_state = S_FETCH;
          end
        end
      end
      default: w_next_state = S_IDLE;
    endcase
  end

endmodule
